// File: rtl/bnn_neuron_bank_seq.sv
// Time-multiplexed bank of XNOR/popcount binary neurons sharing one streamed input vector.
// Each accepted beat adds the masked per-neuron match count; the last beat registers the results.
module bnn_neuron_bank_seq #(
  parameter int unsigned INPUT_SIZE      = 784,
  parameter int unsigned CHUNK           = 16,
  parameter int unsigned NUM_NEURONS     = 4,
  parameter int unsigned THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
  localparam int unsigned NCHUNK         = (INPUT_SIZE + CHUNK - 1) / CHUNK,
  localparam int unsigned IDX_W          = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] threshold,
  input  logic [CHUNK-1:0]                       in_chunk,
  input  logic [NUM_NEURONS*CHUNK-1:0]           weight_chunk,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [IDX_W-1:0]                       chunk_idx,
  output logic                                   busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_NEURONS-1:0]                 out_bits,
  output logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] popcount
);

  localparam int unsigned LAST_BITS = INPUT_SIZE - (NCHUNK - 1) * CHUNK;
  localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_BITS);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]                       chunk_idx_q;
  logic [THRESHOLD_WIDTH-1:0]             acc_q   [NUM_NEURONS];
  logic [THRESHOLD_WIDTH-1:0]             thr_q   [NUM_NEURONS];
  logic [THRESHOLD_WIDTH-1:0]             acc_sum [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]                 out_bits_q;
  logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] popcount_q;
  logic [CHUNK-1:0]                       mask;
  logic                                   last_chunk;
  logic                                   beat;

  assign last_chunk = (chunk_idx_q == IDX_W'(NCHUNK - 1));
  assign beat       = in_valid && in_ready;

  // Padding bits of the final chunk are masked so they never count as matches.
  always_comb begin
    mask = last_chunk ? LAST_MASK : {CHUNK{1'b1}};
    for (int n = 0; n < NUM_NEURONS; n++) begin
      acc_sum[n] = acc_q[n];
      for (int j = 0; j < CHUNK; j++) begin
        acc_sum[n] = acc_sum[n]
                   + THRESHOLD_WIDTH'(mask[j] & ~(in_chunk[j] ^ weight_chunk[n*CHUNK+j]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (beat && last_chunk) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_idx_q <= '0;
      out_bits_q  <= '0;
      popcount_q  <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        acc_q[n] <= '0;
        thr_q[n] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            chunk_idx_q <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
              thr_q[n] <= threshold[n*THRESHOLD_WIDTH +: THRESHOLD_WIDTH];
              acc_q[n] <= '0;
            end
          end
        end
        StAccum: begin
          if (beat) begin
            for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= acc_sum[n];
            if (last_chunk) begin
              chunk_idx_q <= '0;
              for (int n = 0; n < NUM_NEURONS; n++) begin
                popcount_q[n*THRESHOLD_WIDTH +: THRESHOLD_WIDTH] <= acc_sum[n];
                out_bits_q[n] <= (acc_sum[n] >= thr_q[n]);
              end
            end else begin
              chunk_idx_q <= chunk_idx_q + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign chunk_idx = chunk_idx_q;
  assign out_bits  = out_bits_q;
  assign popcount  = popcount_q;

endmodule

// File: tb/tb_bnn_neuron_bank_seq.sv
// Scoreboarded random bench for bnn_neuron_bank_seq (20-bit vector, 8-bit chunks, 2 neurons).
module tb_bnn_neuron_bank_seq;

  localparam int IS = 20;
  localparam int CH = 8;
  localparam int NN = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    threshold = '0;
  logic [7:0]    in_chunk = '0;
  logic [15:0]   weight_chunk = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    chunk_idx;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_bits;
  logic [9:0]    popcount;

  int checks = 0;
  int passes = 0;

  logic [11:0] sb [$];
  logic [7:0]  vin [3];
  logic [15:0] vw  [3];

  bnn_neuron_bank_seq #(
    .INPUT_SIZE(IS),
    .CHUNK(CH),
    .NUM_NEURONS(NN),
    .THRESHOLD_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .threshold(threshold),
    .in_chunk(in_chunk),
    .weight_chunk(weight_chunk),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .chunk_idx(chunk_idx),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits(out_bits),
    .popcount(popcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: count equal bits over the flat 20-bit vector, then compare unsigned.
  function automatic logic [11:0] model(input logic [9:0] thr);
    logic [9:0] pc;
    logic [1:0] bits;
    for (int n = 0; n < NN; n++) begin
      int cnt = 0;
      for (int i = 0; i < IS; i++) begin
        if (vin[i / CH][i % CH] == vw[i / CH][n * CH + i % CH]) cnt++;
      end
      pc[n*TW +: TW] = TW'(cnt);
      bits[n] = (cnt >= int'(thr[n*TW +: TW]));
    end
    return {bits, pc};
  endfunction

  // Monitor: every cycle results are presented they must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("out_bits", 32'(out_bits), 32'(sb[0][11:10]));
          chk("popcount", 32'(popcount), 32'(sb[0][9:0]));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one beat (caller sits just after a rising edge) and wait for acceptance.
  task automatic beat(input int b, input bit ign);
    int t = 0;
    if (ign) begin
      start = 1'b1;
      threshold = '0;
    end
    in_chunk = vin[b];
    weight_chunk = vw[b];
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 8) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    chk("chunk_idx_beat", 32'(chunk_idx), 32'(b));
    if (b == 2) chk("no_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] thr);
    start = 1'b1;
    threshold = thr;
    in_valid = 1'b1;  // must be ignored while idle
    in_chunk = vin[0];
    weight_chunk = vw[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    threshold = 10'($urandom);
  endtask

  task automatic run_vector(input logic [9:0] thr, input int stall, input int hold,
                            input bit ign);
    logic [11:0] exp;
    exp = model(thr);
    do_start(thr);
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("chunk_idx_stall", 32'(chunk_idx), 32'(b));
        @(posedge clk);
        #1;
      end
      if (b == 2) sb.push_back(exp);
      beat(b, ign && (b == 1));
    end
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("chunk_idx_done", 32'(chunk_idx), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    if (ign) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      threshold = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic rand_data();
    for (int b = 0; b < 3; b++) begin
      vin[b] = 8'($urandom);
      vw[b]  = 16'($urandom);
    end
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_popcount", 32'(popcount), 32'd0);
    chk("rst_out_bits", 32'(out_bits), 32'd0);
    chk("rst_chunk_idx", 32'(chunk_idx), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-match, thresholds {20,21}
    rand_data();
    for (int b = 0; b < 3; b++) vw[b] = {vin[b], vin[b]};
    chk("model_allmatch", 32'(model({5'd21, 5'd20})), {20'd0, 2'b01, 5'd20, 5'd20});
    run_vector({5'd21, 5'd20}, 0, 0, 1'b0);

    // Padding mask: all ones vs all ones / all zeros, threshold1 = 0
    for (int b = 0; b < 3; b++) begin
      vin[b] = 8'hFF;
      vw[b]  = 16'h00FF;
    end
    run_vector({5'd0, 5'd20}, 0, 0, 1'b0);
    chk("pad_popcount", 32'(popcount), {22'd0, 5'd0, 5'd20});
    chk("pad_bits", 32'(out_bits), 32'd3);

    // Stall / backpressure
    rand_data();
    run_vector({5'd10, 5'd9}, 3, 5, 1'b0);

    // Ignored start during accumulation and in DONE
    rand_data();
    run_vector({5'd12, 5'd7}, 1, 2, 1'b1);

    // Reset mid-accumulation after beat 1
    rand_data();
    for (int b = 0; b < 3; b++) vw[b] = {vin[b], vin[b]};
    run_vector({5'd3, 5'd3}, 0, 0, 1'b0);
    rand_data();
    do_start({5'd1, 5'd1});
    beat(0, 1'b0);
    beat(1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idx", 32'(chunk_idx), 32'd0);
    chk("mid_rst_popcount", 32'(popcount), 32'd0);
    chk("mid_rst_bits", 32'(out_bits), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_data();
    for (int b = 0; b < 3; b++) vw[b] = {vin[b] ^ 8'hAA, vin[b] ^ 8'hAA};
    run_vector({5'd10, 5'd10}, 0, 0, 1'b0);
    chk("alt_popcount", 32'(popcount), {22'd0, 5'd10, 5'd10});
    chk("alt_bits", 32'(out_bits), 32'd3);

    // Back-to-back random vectors, thresholds spanning 0..22
    for (int k = 0; k < 25; k++) begin
      rand_data();
      run_vector({5'($urandom_range(0, 22)), 5'($urandom_range(0, 22))},
                 $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bnn_neuron_bank_seq.md
Name: bnn_neuron_bank_seq

Overview:
- Time-multiplexed bank of NUM_NEURONS binary (XNOR/popcount) neurons sharing one input vector.
- The vector streams in CHUNK bits per beat over a valid/ready handshake. Each neuron accumulates matching-bit counts across beats, then compares the total against its own threshold.
- Sits between the input buffer / weight ROM and the next BNN layer. Replaces the fully parallel single-neuron datapath for large INPUT_SIZE.

Parameters:
- INPUT_SIZE, 784: length of the binary input vector.
- CHUNK, 16: input bits consumed per accepted beat.
- NUM_NEURONS, 4: neurons evaluated in parallel over the same input stream.
- THRESHOLD_WIDTH, $clog2(INPUT_SIZE+1): width of thresholds and accumulators.
- NCHUNK (localparam), ceil(INPUT_SIZE/CHUNK): beats per vector.
- IDX_W (localparam), max(1,$clog2(NCHUNK)): chunk index width.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle request to begin a new vector. Honoured only in IDLE.
- threshold  in  NUM_NEURONS*THRESHOLD_WIDTH  Per-neuron thresholds; neuron n uses slice n. Sampled on accepted start.
- in_chunk  in  CHUNK  Input bits for the current beat; bit j is vector bit chunk_idx*CHUNK+j.
- weight_chunk  in  NUM_NEURONS*CHUNK  Matching weight bits; neuron n uses slice n.
- in_valid  in  1  in_chunk/weight_chunk valid.
- in_ready  out  1  Block accepts a beat.
- chunk_idx  out  IDX_W  Index of the chunk expected next; drives weight/input memory address.
- busy  out  1  High in ACCUM and DONE.
- out_valid  out  1  Results valid.
- out_ready  in  1  Downstream accepts results.
- out_bits  out  NUM_NEURONS  Bit n = 1 iff popcount[n] >= threshold[n].
- popcount  out  NUM_NEURONS*THRESHOLD_WIDTH  Raw per-neuron match counts.

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready, out_valid, busy, chunk_idx, out_bits, popcount, accumulators and latched thresholds all 0.
- IDLE: in_ready=0. start=1 → latch thresholds, clear accumulators, chunk_idx=0, go ACCUM next cycle.
- ACCUM: in_ready=1 (registered state decode, no combinational path from in_valid).
  - On beat (in_valid&&in_ready): acc[n] += popcount(~(in_chunk ^ w_n) & mask); chunk_idx++.
  - No beat → nothing changes. in_valid may drop for any number of cycles.
- Mask: all ones except on the last chunk (chunk_idx==NCHUNK-1).
  - Last chunk keeps only the low INPUT_SIZE-(NCHUNK-1)*CHUNK bits; padding bits never count regardless of value.
- Last beat: accumulate, compare against latched thresholds (unsigned), register out_bits/popcount, go DONE. out_valid=1 the cycle after the last beat (latency 1). chunk_idx returns to 0.
- DONE: out_valid=1; out_bits/popcount held stable. in_ready=0. On out_valid&&out_ready → IDLE; out_valid=0 next cycle. Outputs retain their last values after leaving DONE.
- Arithmetic: accumulators are THRESHOLD_WIDTH wide; max total is INPUT_SIZE, so no overflow.
  - threshold 0 → bit 1.
  - threshold > INPUT_SIZE → bit 0.
- start outside IDLE is ignored; no restart, thresholds not re-latched.
- start and a beat in the same IDLE cycle: the beat is not accepted (in_ready=0).
- Reset mid-ACCUM or mid-DONE: immediate return to reset values; partial sums discarded.
- NCHUNK==1: single beat, masked as last chunk.

Test Plan (INPUT_SIZE=20, CHUNK=8, NUM_NEURONS=2, so NCHUNK=3 and the last chunk has 4 valid bits):
- All-match: thresholds {20,21}; 3 beats with in=w_n → popcount={20,20}, out_bits=2'b01; out_valid exactly 1 cycle after beat 3.
- Padding mask: in=0xFF, w0=0xFF, w1=0x00 every beat → popcount0=20 (not 24), popcount1=0; threshold1=0 → out_bits[1]=1.
- Stall/backpressure: in_valid low 3 cycles between beats and out_ready low 5 cycles in DONE → sums unchanged, outputs stable, chunk_idx 0→1→2→0; IDLE after out_ready.
- Ignored start: pulse start at beat 2 and in DONE with new thresholds {0,0} → results use the original thresholds; no restart.
- Reset mid-operation: assert rst_n=0 after beat 1 → all outputs 0 the same cycle. A fresh vector of alternating matches (popcount 10), threshold 10 → out_bits[n]=1.
- Back-to-back: start in the cycle after the out handshake → second vector results independent of the first; no residual accumulation.
